// File: rtl/tinydiv.sv
// tinydiv: sequential unsigned restoring divider, one quotient bit per clock, valid/ready on both sides
module tinydiv #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] q,
  output logic [width-1:0] r,
  output logic             div_by_zero
);
  localparam int cw = $clog2(width + 1);
  typedef enum logic [1:0] {idle, busy, done} state_t;
  state_t state;
  logic [width-1:0] dvs, qs, rem, nrem;
  logic [width:0] sh;
  logic [cw-1:0] cnt;
  logic ge;
  assign in_ready = state == idle;
  assign out_valid = state == done;
  // rem < dvs always holds, so the shifted remainder fits in width+1 bits and the restored value in width
  always_comb begin
    sh = {rem, qs[width-1]};
    ge = sh >= {1'b0, dvs};
    nrem = ge ? width'(sh - {1'b0, dvs}) : sh[width-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= idle;
      q <= '0;
      r <= '0;
      div_by_zero <= 1'b0;
      cnt <= '0;
      rem <= '0;
      qs <= '0;
      dvs <= '0;
    end else begin
      case (state)
        idle: if (in_valid) begin
          if (b == '0) begin
            q <= '1;
            r <= a;
            div_by_zero <= 1'b1;
            state <= done;
          end else begin
            dvs <= b;
            qs <= a;
            rem <= '0;
            cnt <= cw'(width);
            state <= busy;
          end
        end
        busy: begin
          rem <= nrem;
          qs <= {qs[width-2:0], ge};
          cnt <= cnt - cw'(1);
          if (cnt == cw'(1)) begin
            q <= {qs[width-2:0], ge};
            r <= nrem;
            div_by_zero <= 1'b0;
            state <= done;
          end
        end
        done: if (out_ready) state <= idle;
        default: state <= idle;
      endcase
    end
  end
endmodule

// File: tb/tb_tinydiv.sv
// tb_tinydiv: scoreboard bench for width=8 and width=4 dividers, random operands vs an arithmetic model
module tb_tinydiv;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic iv[2], ordy[2];
  logic [7:0] av[2], bv[2];
  logic [7:0] q8, r8;
  logic [3:0] q4, r4;
  logic irdy8, ov8, dz8, irdy4, ov4, dz4;
  logic irdy[2], ov[2], dz[2];
  logic [7:0] qv[2], rv[2];
  tinydiv #(.width(8)) u8 (.clk(clk), .reset(rst), .in_valid(iv[0]), .in_ready(irdy8), .a(av[0]), .b(bv[0]),
    .out_valid(ov8), .out_ready(ordy[0]), .q(q8), .r(r8), .div_by_zero(dz8));
  tinydiv #(.width(4)) u4 (.clk(clk), .reset(rst), .in_valid(iv[1]), .in_ready(irdy4), .a(av[1][3:0]), .b(bv[1][3:0]),
    .out_valid(ov4), .out_ready(ordy[1]), .q(q4), .r(r4), .div_by_zero(dz4));
  always_comb begin
    irdy[0] = irdy8; ov[0] = ov8; dz[0] = dz8; qv[0] = q8; rv[0] = r8;
    irdy[1] = irdy4; ov[1] = ov4; dz[1] = dz4; qv[1] = {4'h0, q4}; rv[1] = {4'h0, r4};
  end
  int cyc = 0;
  always @(posedge clk) cyc++;
  typedef struct {logic [7:0] q; logic [7:0] r; logic dz; int lat; int acc;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;
  bit rand_or = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // lat = edges after the accepting edge until out_valid is seen
  function automatic exp_t model(input int d, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int w = d ? 4 : 8;
    if (y == 0) begin
      e.q = 8'((1 << w) - 1); e.r = x; e.dz = 1'b1; e.lat = 0;
    end else begin
      e.q = x / y; e.r = x % y; e.dz = 1'b0; e.lat = w;
    end
    e.acc = 0;
    return e;
  endfunction
  task automatic op(input int d, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int t = 0;
    while (!irdy[d] && t < 200) begin @(negedge clk); t++; end
    if (!irdy[d]) begin chk("accept_timeout", 0, 1); return; end
    e = model(d, x, y);
    e.acc = cyc + 1;
    sb.push_back(e);
    iv[d] = 1'b1; av[d] = x; bv[d] = y;
    @(negedge clk);
    iv[d] = 1'b0; av[d] = 8'($urandom); bv[d] = 8'($urandom);
  endtask
  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || ov[0] || ov[1]) && t < 1000) begin @(negedge clk); t++; end
    chk("drain", sb.size(), 0);
  endtask
  initial forever begin
    @(negedge clk);
    if (rand_or) begin
      ordy[0] = ($urandom % 3) != 0;
      ordy[1] = ($urandom % 3) != 0;
    end
  end
  logic pov[2];
  logic [7:0] hq[2], hr[2];
  logic hdz[2];
  initial begin
    exp_t e;
    pov[0] = 1'b0; pov[1] = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (rst) pov[d] = 1'b0;
        else begin
          if (pov[d] && ordy[d]) begin
            if (sb.size() == 0) chk("result_without_op", 1, 0);
            else begin
              e = sb.pop_front();
              chk("q", hq[d], e.q);
              chk("r", hr[d], e.r);
              chk("div_by_zero", hdz[d], e.dz);
            end
            chk("q_kept_after_handoff", qv[d], hq[d]);
            chk("out_valid_after_handoff", ov[d], 0);
            chk("in_ready_after_handoff", irdy[d], 1);
          end else if (pov[d]) begin
            chk("hold_out_valid", ov[d], 1);
            chk("hold_q", qv[d], hq[d]);
            chk("hold_r", rv[d], hr[d]);
            chk("hold_dz", dz[d], hdz[d]);
            chk("hold_in_ready", irdy[d], 0);
          end else if (ov[d]) begin
            if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
            else chk("latency", cyc - sb[0].acc, sb[0].lat);
            chk("in_ready_in_done", irdy[d], 0);
          end
          if (ov[d]) begin hq[d] = qv[d]; hr[d] = rv[d]; hdz[d] = dz[d]; end
          pov[d] = ov[d];
        end
      end
    end
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    int t;
    logic [7:0] x, y;
    rst = 1'b1;
    iv[0] = 1'b0; iv[1] = 1'b0; ordy[0] = 1'b1; ordy[1] = 1'b1;
    av[0] = '0; av[1] = '0; bv[0] = '0; bv[1] = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_q", qv[d], 0);
      chk("reset_r", rv[d], 0);
      chk("reset_dz", dz[d], 0);
      chk("reset_out_valid", ov[d], 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", irdy[0], 1);
    op(0, 100, 7); op(0, 5, 9); op(0, 255, 1); op(0, 255, 255);
    op(0, 42, 0); op(0, 9, 3); op(0, 0, 0); op(0, 0, 200);
    drain();
    ordy[0] = 1'b0;
    op(0, 200, 13);
    t = 0;
    while (!ov[0] && t < 50) begin @(negedge clk); t++; end
    chk("backpressure_out_valid", ov[0], 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv[0] = ~iv[0]; av[0] = 8'd3; bv[0] = 8'd1;
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    drain();
    op(0, 77, 4);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("midreset_out_valid", ov[0], 0);
    chk("midreset_q", qv[0], 0);
    chk("midreset_r", rv[0], 0);
    chk("midreset_in_ready", irdy[0], 1);
    op(0, 77, 4);
    drain();
    rand_or = 1;
    for (int i = 0; i < 2000; i++) begin
      x = ($urandom % 8 == 0) ? 8'd255 : 8'($urandom);
      case ($urandom % 8)
        0: y = 8'd0;
        1: y = 8'd1;
        2: y = 8'd255;
        default: y = 8'($urandom);
      endcase
      op(0, x, y);
    end
    drain();
    for (int xa = 0; xa < 16; xa++)
      for (int yb = 0; yb < 16; yb++) op(1, 8'(xa), 8'(yb));
    drain();
    rand_or = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
